traffic_sched: RTL



---
 rtl/traffic_sched.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/traffic_sched.sv
// traffic_sched: phase scheduler for one road crossing.
//
// The main road holds green by default. Side-road and pedestrian requests are
// latched and served with fixed priority, pedestrian first. Every phase change
// passes through yellow and all-red clearance, so conflicting movements never
// overlap.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   side_req   side-road vehicle request (pulse or level)
//   ped_req    pedestrian button (pulse or level)
//   main_out   main lamps {red,yellow,green}
//   side_out   side lamps {red,yellow,green}
//   ped_out    pedestrian lamps {dont_walk,wait,walk}
//   phase_out  current state code (debug)
//
// State table:
//   state    | meaning
//   MAIN_GO  | main green; holds after minimum time until a request is pending
//   MAIN_YEL | main yellow
//   CLR_A    | all red after main; picks pedestrian or side service
//   SIDE_GO  | side green
//   SIDE_YEL | side yellow
//   CLR_B    | all red after side, back to main
//   PED_WALK | pedestrian walk
//   CLR_P    | all red after walk; side next if pending, else main

module traffic_sched #(
  parameter int TICK_DIV   = 4,
  parameter int T_MAIN_MIN = 8,
  parameter int T_YEL      = 3,
  parameter int T_CLR      = 2,
  parameter int T_SIDE     = 6,
  parameter int T_WALK     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] main_out,
  output logic [2:0] side_out,
  output logic [2:0] ped_out,
  output logic [2:0] phase_out
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_MAIN_MIN, T_YEL), max2(T_CLR, T_SIDE)), T_WALK);
  // The timer only ever holds duration-1.
  localparam int TW = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    MAIN_GO  = 3'd0,
    MAIN_YEL = 3'd1,
    CLR_A    = 3'd2,
    SIDE_GO  = 3'd3,
    SIDE_YEL = 3'd4,
    CLR_B    = 3'd5,
    PED_WALK = 3'd6,
    CLR_P    = 3'd7
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic          side_pend;
  logic          side_pend_nxt;
  logic          ped_pend;
  logic          ped_pend_nxt;
  logic          tick;
  logic          expiry;

  function automatic logic [TW-1:0] load_val(input state_t s);
    logic [TW-1:0] v;
    case (s)
      MAIN_GO:            v = TW'(T_MAIN_MIN - 1);
      MAIN_YEL, SIDE_YEL: v = TW'(T_YEL - 1);
      SIDE_GO:            v = TW'(T_SIDE - 1);
      PED_WALK:           v = TW'(T_WALK - 1);
      default:            v = TW'(T_CLR - 1);
    endcase
    return v;
  endfunction

  function automatic logic [2:0] main_lamp(input state_t s);
    logic [2:0] v;
    case (s)
      MAIN_GO:  v = 3'b001;
      MAIN_YEL: v = 3'b010;
      default:  v = 3'b100;
    endcase
    return v;
  endfunction

  function automatic logic [2:0] side_lamp(input state_t s);
    logic [2:0] v;
    case (s)
      SIDE_GO:  v = 3'b001;
      SIDE_YEL: v = 3'b010;
      default:  v = 3'b100;
    endcase
    return v;
  endfunction

  // The wait lamp mirrors the pending pedestrian request in every state.
  function automatic logic [2:0] ped_lamp(input state_t s, input logic pend);
    logic [2:0] v;
    if (s == PED_WALK) v = {1'b0, pend, 1'b1};
    else               v = {1'b1, pend, 1'b0};
    return v;
  endfunction

  always_comb begin
    tick   = (presc == PW'(TICK_DIV - 1));
    expiry = tick && (timer == '0);

    state_nxt = state;
    if (expiry) begin
      case (state)
        MAIN_GO:  if (side_pend || ped_pend) state_nxt = MAIN_YEL;
        MAIN_YEL: state_nxt = CLR_A;
        CLR_A:    state_nxt = ped_pend ? PED_WALK : SIDE_GO;
        SIDE_GO:  state_nxt = SIDE_YEL;
        SIDE_YEL: state_nxt = CLR_B;
        CLR_B:    state_nxt = MAIN_GO;
        PED_WALK: state_nxt = CLR_P;
        CLR_P:    state_nxt = side_pend ? SIDE_GO : MAIN_GO;
        default:  state_nxt = MAIN_GO;
      endcase
    end

    // Idle MAIN_GO keeps the prescaler running with the timer parked at 0,
    // so a late request is picked up on the next tick.
    if (state_nxt != state) begin
      presc_nxt = '0;
      timer_nxt = load_val(state_nxt);
    end else begin
      presc_nxt = tick ? '0 : presc + 1'b1;
      timer_nxt = (tick && (timer != '0)) ? timer - 1'b1 : timer;
    end

    // Entering the serving state clears the latch and beats a same-cycle set.
    side_pend_nxt = side_pend;
    if (side_req && (state != SIDE_GO)) side_pend_nxt = 1'b1;
    if ((state_nxt == SIDE_GO) && (state != SIDE_GO)) side_pend_nxt = 1'b0;

    ped_pend_nxt = ped_pend;
    if (ped_req && (state != PED_WALK)) ped_pend_nxt = 1'b1;
    if ((state_nxt == PED_WALK) && (state != PED_WALK)) ped_pend_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MAIN_GO;
      presc     <= '0;
      timer     <= TW'(T_MAIN_MIN - 1);
      side_pend <= 1'b0;
      ped_pend  <= 1'b0;
      main_out  <= 3'b001;
      side_out  <= 3'b100;
      ped_out   <= 3'b100;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      timer     <= timer_nxt;
      side_pend <= side_pend_nxt;
      ped_pend  <= ped_pend_nxt;
      // Lamps are decoded from the next state so they change with it.
      main_out  <= main_lamp(state_nxt);
      side_out  <= side_lamp(state_nxt);
      ped_out   <= ped_lamp(state_nxt, ped_pend_nxt);
    end
  end

  assign phase_out = state;

endmodule
